// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter.
//   PAR_*        parity mode encodings for the PARITY parameter
//   uart_state_t framing FSM states
//   frame_bits() total serial bits in one frame for a given configuration
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} uart_state_t;

  function automatic int frame_bits(int data_bits, int parity, int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_param_if.sv
// Word-queue handshake into the UART transmitter.
//   tx_data  word to queue
//   tx_valid tx_data is valid this cycle
//   tx_ready transmitter FIFO can accept a word this cycle
interface uart_tx_fifo_param_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO, power-of-two depth, pointers wrap naturally.
//   clk, rst_n   clock, async active-low reset
//   push, wdata  write request (ignored when full)
//   pop, rdata   read request (ignored when empty); rdata shows the head word
//   count        words stored; full/empty decoded from count
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with an input word FIFO.
//   clk, rst_n  clock, async active-low reset (forces txd high at once)
//   baud_div    cycles per serial bit, sampled at frame start, 0 acts as 1
//   tx          valid/ready word handshake (slave side)
//   txd         registered serial line, idle high
//   busy        a frame is in progress
//   fifo_count  words queued, excluding the word being shifted
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIV_W-1:0]              baud_div,
  uart_tx_fifo_param_if.slave           tx,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_t          state, state_nx;
  logic [DIV_W-1:0]     eff_div, eff_div_nx, baud_cnt, baud_cnt_nx, new_div;
  logic [2:0]           bit_idx, bit_idx_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx, head;
  logic                 par_bit, par_bit_nx, txd_nx, busy_nx;
  logic                 pop, load, full, empty, bit_end;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx.tx_valid),
    .wdata (tx.tx_data),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  assign tx.tx_ready = !full;
  assign bit_end     = (baud_cnt == '0);
  assign new_div     = (baud_div == '0) ? DIV_W'(1) : baud_div;

  always_comb begin
    state_nx    = state;
    eff_div_nx  = eff_div;
    bit_idx_nx  = bit_idx;
    shreg_nx    = shreg;
    par_bit_nx  = par_bit;
    txd_nx      = txd;
    load        = 1'b0;
    // Down-counter reloads at each bit boundary.
    baud_cnt_nx = bit_end ? eff_div - 1'b1 : baud_cnt - 1'b1;
    case (state)
      IDLE: begin
        txd_nx      = 1'b1;
        baud_cnt_nx = '0;
        load        = !empty;
      end
      START: if (bit_end) begin
        state_nx   = DATA;
        txd_nx     = shreg[0];
        bit_idx_nx = '0;
      end
      DATA: if (bit_end) begin
        if (bit_idx == LAST_DATA) begin
          bit_idx_nx = '0;
          if (PARITY != PAR_NONE) begin
            state_nx = PAR;
            txd_nx   = par_bit;
          end else begin
            state_nx = STOP;
            txd_nx   = 1'b1;
          end
        end else begin
          bit_idx_nx = bit_idx + 1'b1;
          shreg_nx   = shreg >> 1;
          txd_nx     = shreg[1];
        end
      end
      PAR: if (bit_end) begin
        state_nx = STOP;
        txd_nx   = 1'b1;
      end
      STOP: if (bit_end) begin
        if (bit_idx == LAST_STOP) begin
          bit_idx_nx = '0;
          // Queued word starts immediately: no idle cycle between frames.
          if (!empty) load = 1'b1;
          else        state_nx = IDLE;
        end else begin
          bit_idx_nx = bit_idx + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (load) begin
      state_nx    = START;
      shreg_nx    = head;
      par_bit_nx  = (PARITY == PAR_ODD) ? ~^head : ^head;
      eff_div_nx  = new_div;
      baud_cnt_nx = new_div - 1'b1;
      txd_nx      = 1'b0;
    end
    pop     = load;
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      eff_div  <= DIV_W'(1);
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      txd      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      eff_div  <= eff_div_nx;
      baud_cnt <= baud_cnt_nx;
      bit_idx  <= bit_idx_nx;
      shreg    <= shreg_nx;
      par_bit  <= par_bit_nx;
      txd      <= txd_nx;
      busy     <= busy_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Three transmitter configurations (8N1/d4, 7E2/d4, 7O1/d2) share one
// stimulus stream; each is compared every cycle against a queue-based
// frame model built from the serial framing rules.
module tb_uart_tx_fifo_param;
  import uart_pkg::*;

  localparam int NCFG = 3;
  localparam int CFG_DB [NCFG] = '{8, 7, 7};
  localparam int CFG_PA [NCFG] = '{PAR_NONE, PAR_EVEN, PAR_ODD};
  localparam int CFG_SB [NCFG] = '{1, 2, 1};
  localparam int CFG_FD [NCFG] = '{4, 4, 2};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baud_div;
  logic [7:0]  tx_data;
  logic        tx_valid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
    localparam int DB = CFG_DB[gi];
    localparam int PA = CFG_PA[gi];
    localparam int SB = CFG_SB[gi];
    localparam int FD = CFG_FD[gi];

    uart_tx_fifo_param_if #(.DATA_BITS(DB)) bus ();
    logic                  txd, busy;
    logic [$clog2(FD):0]   cnt;

    assign bus.tx_data  = tx_data[DB-1:0];
    assign bus.tx_valid = tx_valid;

    uart_tx_fifo_param #(
      .DATA_BITS(DB), .PARITY(PA), .STOP_BITS(SB), .FIFO_DEPTH(FD), .DIV_W(16)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .baud_div   (baud_div),
      .tx         (bus),
      .txd        (txd),
      .busy       (busy),
      .fifo_count (cnt)
    );

    // Reference: queued words, plus the remaining bits of the frame on the
    // line and how many cycles the current bit still has to run.
    int q[$];
    int bits[$];
    int cyc = 0;
    int div = 1;
    bit act = 1'b0;

    initial begin
      bit push;
      int w, par, b;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          q.delete();
          bits.delete();
          act = 1'b0;
          cyc = 0;
        end else begin
          push = tx_valid && (q.size() != FD);
          w    = int'(tx_data) & ((1 << DB) - 1);
          if (act) begin
            cyc--;
            if (cyc == 0) begin
              void'(bits.pop_front());
              if (bits.size() == 0) act = 1'b0;
              else                  cyc = div;
            end
          end
          if (!act && q.size() > 0) begin
            b   = q.pop_front();
            div = (baud_div == 0) ? 1 : int'(baud_div);
            bits.delete();
            bits.push_back(0);
            par = 0;
            for (int i = 0; i < DB; i++) begin
              bits.push_back((b >> i) & 1);
              par ^= (b >> i) & 1;
            end
            if (PA == PAR_EVEN) bits.push_back(par);
            if (PA == PAR_ODD)  bits.push_back(par ^ 1);
            for (int i = 0; i < SB; i++) bits.push_back(1);
            if (bits.size() != frame_bits(DB, PA, SB))
              $display("model frame length %0d unexpected", bits.size());
            act = 1'b1;
            cyc = div;
          end
          if (push) q.push_back(w);
        end
      end
    end

    initial begin
      forever begin
        @(negedge clk);
        check($sformatf("u%0d.txd", gi), int'(txd), act ? bits[0] : 1);
        check($sformatf("u%0d.busy", gi), int'(busy), int'(act));
        check($sformatf("u%0d.fifo_count", gi), int'(cnt), q.size());
        check($sformatf("u%0d.tx_ready", gi), int'(bus.tx_ready), int'(q.size() != FD));
      end
    end

    // Reset must act on the outputs without a clock edge.
    initial begin
      forever begin
        @(negedge rst_n);
        #1;
        check($sformatf("u%0d.rst_txd", gi), int'(txd), 1);
        check($sformatf("u%0d.rst_busy", gi), int'(busy), 0);
        check($sformatf("u%0d.rst_count", gi), int'(cnt), 0);
        check($sformatf("u%0d.rst_ready", gi), int'(bus.tx_ready), 1);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    baud_div = 16'd4;
    cycles(3);
    rst_n = 1'b1;
    cycles(2);

    // Single 0xA5 into an idle block at 4 cycles per bit.
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    cycles(1);
    tx_valid = 1'b0;
    cycles(frame_bits(7, PAR_EVEN, 2) * 4 + 10);

    // 0x53, 2 cycles per bit: exercises 7-bit parity frames.
    baud_div = 16'd2;
    tx_data  = 8'h53;
    tx_valid = 1'b1;
    cycles(1);
    tx_valid = 1'b0;
    cycles(40);

    // Slow frames with valid held: fills the FIFO and stalls the source.
    baud_div = 16'd10;
    tx_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tx_data = 8'($urandom);
      cycles(20);
    end
    tx_valid = 1'b0;
    cycles(800);

    // Back-to-back frames from three queued words.
    baud_div = 16'd1;
    tx_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tx_data = 8'($urandom);
      cycles(1);
    end
    tx_valid = 1'b0;
    cycles(60);

    // Randomised traffic, divisor 0..3 changing under running frames.
    for (int c = 0; c < 4000; c++) begin
      tx_valid = ($urandom_range(0, 3) == 0) || (c >= 2000 && c < 2400);
      tx_data  = 8'($urandom);
      if ($urandom_range(0, 49) == 0) baud_div = 16'($urandom_range(0, 3));
      cycles(1);
    end
    tx_valid = 1'b0;
    cycles(300);

    // Divisor 3 -> 8 mid-frame: first frame keeps 3, second uses 8.
    baud_div = 16'd3;
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    cycles(1);
    tx_data  = 8'hC3;
    cycles(1);
    tx_valid = 1'b0;
    cycles(8);
    baud_div = 16'd8;
    cycles(260);

    // Reset in the middle of a frame of zero data bits.
    baud_div = 16'd3;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    cycles(1);
    tx_data  = 8'hFF;
    cycles(2);
    tx_valid = 1'b0;
    cycles(6);
    #2 rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
